// File: rtl/seg_display_mux_pkg.sv
// Shared segment encodings for the multiplexed seven-segment display.
// Patterns are active-low: bit 7 = dp, bits 6:0 = g..a.
package seg_display_mux_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_0     = 8'hC0;
    localparam seg_t SEG_1     = 8'hF9;
    localparam seg_t SEG_2     = 8'hA4;
    localparam seg_t SEG_3     = 8'hB0;
    localparam seg_t SEG_4     = 8'h99;
    localparam seg_t SEG_5     = 8'h92;
    localparam seg_t SEG_6     = 8'h82;
    localparam seg_t SEG_7     = 8'hF8;
    localparam seg_t SEG_8     = 8'h80;
    localparam seg_t SEG_9     = 8'h90;
    localparam seg_t SEG_A     = 8'h88;
    localparam seg_t SEG_B     = 8'h83;
    localparam seg_t SEG_C     = 8'hC6;
    localparam seg_t SEG_D     = 8'hA1;
    localparam seg_t SEG_E     = 8'h86;
    localparam seg_t SEG_F     = 8'h8E;
    localparam seg_t SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to seven-segment decoder; letters only when hex_en is set.
module seg_hex_decode
    import seg_display_mux_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_en,
    output seg_t       pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:  pattern = SEG_0;
            4'd1:  pattern = SEG_1;
            4'd2:  pattern = SEG_2;
            4'd3:  pattern = SEG_3;
            4'd4:  pattern = SEG_4;
            4'd5:  pattern = SEG_5;
            4'd6:  pattern = SEG_6;
            4'd7:  pattern = SEG_7;
            4'd8:  pattern = SEG_8;
            4'd9:  pattern = SEG_9;
            4'd10: pattern = hex_en ? SEG_A : SEG_BLANK;
            4'd11: pattern = hex_en ? SEG_B : SEG_BLANK;
            4'd12: pattern = hex_en ? SEG_C : SEG_BLANK;
            4'd13: pattern = hex_en ? SEG_D : SEG_BLANK;
            4'd14: pattern = hex_en ? SEG_E : SEG_BLANK;
            default: pattern = hex_en ? SEG_F : SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment driver with shadowed digit data,
// leading-zero blanking, per-digit decimal points and blinking.
module seg_display_mux
    import seg_display_mux_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250,
    parameter int HEX_MODE    = 0
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int BLK_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

    logic [CNT_W-1:0]        refresh_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] digits_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   mask_sh;

    logic                    tick;
    logic [3:0]              code_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [3:0]              sel_code;
    seg_t                    sel_pattern;
    logic                    hex_en;
    logic                    blink_off;
    logic                    lz_blank;
    seg_t                    seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    assign tick   = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
    assign hex_en = (HEX_MODE != 0);

    // upper_zero[i]: digit i and every more-significant digit hold code 0
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign code_arr[gi]   = digits_sh[4*gi +: 4];
            assign upper_zero[gi] = (digits_sh[4*NUM_DIGITS-1 : 4*gi] == '0);
        end
    endgenerate

    assign sel_code = code_arr[idx];

    seg_hex_decode u_decode (
        .code    (sel_code),
        .hex_en  (hex_en),
        .pattern (sel_pattern)
    );

    always_comb begin
        blink_off = blink_phase && mask_sh[idx];
        lz_blank  = blank_lz && (idx != '0) && upper_zero[idx];
        an_next   = ~(NUM_DIGITS'(1) << idx);
        seg_next  = {~dp_sh[idx], (lz_blank ? SEG_BLANK[6:0] : sel_pattern[6:0])};
        if (blink_off) begin
            an_next  = '1;
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            digits_sh   <= '0;
            dp_sh       <= '0;
            mask_sh     <= '0;
            seg         <= SEG_BLANK;
            an          <= '1;
        end else begin
            if (tick) begin
                refresh_cnt <= '0;
                idx         <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            if (load) begin
                digits_sh <= digits;
                dp_sh     <= dp_en;
                mask_sh   <= blink_mask;
            end
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule
